// File: rtl/gray_decode_arbiter.sv
// Round-robin arbiter in front of one shared Gray-to-binary decoder.
// The decoded word sits in a single registered output slot with a valid/ready handshake.
module gray_decode_arbiter #(
    parameter  int N       = 4,
    parameter  int NUM_REQ = 4,
    localparam int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*N-1:0] req_gray,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N-1:0]         out_bin,
    output logic [IDW-1:0]       out_id
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t         state;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] cand;
    logic [IDW-1:0] win;
    logic           found;
    logic           slot_free;
    logic           grant;
    logic [N-1:0]   dec_bin;

    function automatic logic [IDW-1:0] wrap(input int v);
        return IDW'(v % NUM_REQ);
    endfunction

    function automatic logic [N-1:0] gray2bin(input logic [N-1:0] g);
        logic [N-1:0] b;
        b[N-1] = g[N-1];
        for (int k = N - 2; k >= 0; k--)
            b[k] = g[k] ^ b[k+1];
        return b;
    endfunction

    assign out_valid = (state == FULL);
    assign slot_free = (state == EMPTY) | (out_valid & out_ready);

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = wrap(int'(rr_ptr) + k);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
        grant   = found & slot_free;
        dec_bin = gray2bin(req_gray[int'(win)*N +: N]);
    end

    // Masked during reset so no requester sees a strobe that the held-in-reset slot ignores.
    always_comb begin
        req_ready = '0;
        if (grant && !rst)
            req_ready[win] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= EMPTY;
            out_bin <= '0;
            out_id  <= '0;
            rr_ptr  <= '0;
        end else if (grant) begin
            state   <= FULL;
            out_bin <= dec_bin;
            out_id  <= win;
            rr_ptr  <= wrap(int'(win) + 1);
        end else if (out_valid && out_ready) begin
            state <= EMPTY;
        end
    end

endmodule
